// File: rtl/tero_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tero_sweep_ctrl_pkg
// Brief    : State codes and default widths shared by the TERO sweep logic.
// Revision : 1.0
// ============================================================================
package tero_sweep_ctrl_pkg;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_osc   = 3'd2;
    localparam logic [2:0] c_st_drain = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_fini  = 3'd5;

    localparam int c_sel_w_def        = 20;
    localparam int c_samples_log2_def = 12;

endpackage : tero_sweep_ctrl_pkg
`default_nettype wire

// File: rtl/tero_osc_wdt.sv
`default_nettype none
// ============================================================================
// Module   : tero_osc_wdt
// Brief    : OSC-state watchdog with a saturating expiry counter.
// Revision : 1.0
// ============================================================================
module tero_osc_wdt #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        OSC_ACTIVE,
    input  logic        TERO_OE,
    output logic        TMO_PULSE,
    output logic [15:0] TMO_CNT
);

    localparam logic [15:0] c_wdt_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wdt;
    logic [15:0] r_tmo_cnt;

    // r_wdt holds the number of OSC cycles already elapsed, so it reads 0 in the first one
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wdt <= '0;
        end else if (!OSC_ACTIVE) begin
            r_wdt <= '0;
        end else if (r_wdt != 16'hFFFF) begin
            r_wdt <= r_wdt + 16'd1;
        end
    end

    assign TMO_PULSE = OSC_ACTIVE && !TERO_OE && (r_wdt == c_wdt_last);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tmo_cnt <= '0;
        end else if (TMO_PULSE && (r_tmo_cnt != 16'hFFFF)) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign TMO_CNT = r_tmo_cnt;

endmodule : tero_osc_wdt
`default_nettype wire

// File: rtl/tero_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tero_sweep_ctrl
// Brief    : TERO sample sequencer and RO_SEL sweeper; TERO_SWEEP_TIMEOUT_EN
//            adds an OSC watchdog that forces a sample on expiry.
// Revision : 1.0
// ============================================================================
module tero_sweep_ctrl
    import tero_sweep_ctrl_pkg::*;
#(
    parameter int SEL_W        = c_sel_w_def,
    parameter int SAMPLES_LOG2 = c_samples_log2_def,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             FIXED,
    input  logic [SEL_W-1:0] SEL_FIRST,
    input  logic [SEL_W-1:0] SEL_LAST,
    output logic             CTR,
    output logic [SEL_W-1:0] RO_SEL,
    input  logic             TERO_OE,
    input  logic             UART_READY,
    input  logic             UART_EMPTY,
    input  logic             UART_FULL,
    output logic             BUSY,
    output logic             DONE,
    output logic             TMO_PULSE,
    output logic [15:0]      TMO_CNT
);

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    r_fixed;
    logic [SEL_W-1:0]        r_sel;
    logic [SEL_W-1:0]        r_sel_last;
    logic [SAMPLES_LOG2-1:0] r_cnt;
    logic                    w_tmo_expire;
    logic                    w_sample;
    logic                    w_launch;

`ifdef TERO_SWEEP_TIMEOUT_EN
    tero_osc_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_osc_wdt (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .OSC_ACTIVE (r_state == c_st_osc),
        .TERO_OE    (TERO_OE),
        .TMO_PULSE  (w_tmo_expire),
        .TMO_CNT    (TMO_CNT)
    );
    assign TMO_PULSE = w_tmo_expire;
`else
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = ^(16'(TIMEOUT_CYC));
    assign w_tmo_expire     = 1'b0;
    assign TMO_PULSE        = 1'b0;
    assign TMO_CNT          = 16'd0;
`endif

    // A watchdog expiry is treated exactly like a real sample strobe
    assign w_sample = TERO_OE || w_tmo_expire;
    assign w_launch = START && !STOP && ((r_state == c_st_idle) || (r_state == c_st_fini));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (STOP) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle, c_st_fini: begin
                    if (START) w_state_nxt = c_st_start;
                end
                c_st_start: w_state_nxt = c_st_osc;
                c_st_osc: begin
                    if (w_sample) begin
                        if (UART_FULL)    w_state_nxt = c_st_drain;
                        else if (r_fixed) w_state_nxt = c_st_start;
                        else if (&r_cnt)  w_state_nxt = c_st_next;
                        else              w_state_nxt = c_st_start;
                    end
                end
                c_st_drain: begin
                    // cnt has already wrapped to zero when the last sample of a setting detoured here
                    if (UART_EMPTY) begin
                        w_state_nxt = (!r_fixed && (r_cnt == '0)) ? c_st_next : c_st_start;
                    end
                end
                c_st_next: begin
                    if (UART_READY) begin
                        w_state_nxt = (r_sel == r_sel_last) ? c_st_fini : c_st_start;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_comb begin
        CTR  = (r_state == c_st_osc);
        BUSY = (r_state == c_st_start) || (r_state == c_st_osc) ||
               (r_state == c_st_drain) || (r_state == c_st_next);
        DONE = (r_state == c_st_fini);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fixed    <= 1'b0;
            r_sel      <= '0;
            r_sel_last <= '0;
            r_cnt      <= '0;
        end else if (!STOP) begin
            if (w_launch) begin
                r_fixed    <= FIXED;
                r_sel      <= SEL_FIRST;
                r_sel_last <= SEL_LAST;
                r_cnt      <= '0;
            end
            if ((r_state == c_st_osc) && w_sample) begin
                r_cnt <= r_cnt + SAMPLES_LOG2'(1);
            end
            if ((r_state == c_st_next) && UART_READY && (r_sel != r_sel_last)) begin
                r_sel <= r_sel + SEL_W'(1);
            end
        end
    end

    assign RO_SEL = r_sel;

endmodule : tero_sweep_ctrl
`default_nettype wire

// File: tb/tb_tero_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tero_sweep_ctrl
// Brief    : Directed self-checking bench for tero_sweep_ctrl.
// Revision : 1.0
// ============================================================================
module tb_tero_sweep_ctrl;

    localparam int SEL_W = 20;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             FIXED = 1'b0;
    logic [SEL_W-1:0] SEL_FIRST = '0;
    logic [SEL_W-1:0] SEL_LAST = '0;
    logic             CTR;
    logic [SEL_W-1:0] RO_SEL;
    logic             TERO_OE = 1'b0;
    logic             UART_READY = 1'b1;
    logic             UART_EMPTY = 1'b1;
    logic             UART_FULL = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic             TMO_PULSE;
    logic [15:0]      TMO_CNT;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    tero_sweep_ctrl #(
        .SEL_W        (SEL_W),
        .SAMPLES_LOG2 (2),
        .TIMEOUT_CYC  (100)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .STOP       (STOP),
        .FIXED      (FIXED),
        .SEL_FIRST  (SEL_FIRST),
        .SEL_LAST   (SEL_LAST),
        .CTR        (CTR),
        .RO_SEL     (RO_SEL),
        .TERO_OE    (TERO_OE),
        .UART_READY (UART_READY),
        .UART_EMPTY (UART_EMPTY),
        .UART_FULL  (UART_FULL),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .TMO_PULSE  (TMO_PULSE),
        .TMO_CNT    (TMO_CNT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic fixed, input logic [SEL_W-1:0] first, input logic [SEL_W-1:0] last);
        FIXED = fixed; SEL_FIRST = first; SEL_LAST = last;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Waits (bounded) for CTR, holds it dly cycles, then strobes TERO_OE.
    task automatic sample_once(input int dly, input bit full, output logic [SEL_W-1:0] sel, output bit ok);
        ok = 1'b0;
        sel = 'x;
        for (int i = 0; i < 64; i++) begin
            if (CTR === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) return;
        sel = RO_SEL;
        repeat (dly) tick();
        TERO_OE = 1'b1;
        if (full) begin UART_FULL = 1'b1; UART_EMPTY = 1'b0; end
        tick();
        TERO_OE = 1'b0;
        UART_FULL = 1'b0;
    endtask

    task automatic wait_ctr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (CTR === 1'b1) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        #12;
        n_checks++; if (CTR !== 1'b0)     $display("FAIL reset_ctr: got %b want 0", CTR);           else n_pass++;
        n_checks++; if (RO_SEL !== '0)    $display("FAIL reset_rosel: got %h want 0", RO_SEL);      else n_pass++;
        n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", BUSY, DONE); else n_pass++;
        n_checks++; if (TMO_PULSE !== 1'b0 || TMO_CNT !== 16'd0) $display("FAIL reset_tmo: got %b/%h want 0/0000", TMO_PULSE, TMO_CNT); else n_pass++;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic_sweep();
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] exp_sel;
        bit ok;
        start_run(1'b0, 20'd5, 20'd7);
        for (int s = 0; s < 12; s++) begin
            sample_once(3, 1'b0, sel, ok);
            exp_sel = 20'd5 + 20'(s / 4);
            n_checks++; if (sel !== exp_sel) $display("FAIL basic_sel[%0d]: got %h want %h", s, sel, exp_sel); else n_pass++;
            n_checks++; if (CTR !== 1'b0)    $display("FAIL basic_ctr_gap[%0d]: got %b want 0", s, CTR);       else n_pass++;
        end
        tick();
        n_checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) $display("FAIL basic_done: got done=%b busy=%b want 1 0", DONE, BUSY); else n_pass++;
        n_checks++; if (RO_SEL !== 20'd7) $display("FAIL basic_final_sel: got %h want 7", RO_SEL); else n_pass++;
    endtask

    task automatic test_back_pressure();
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] exp_sel;
        bit ok;
        int bad;
        start_run(1'b0, 20'd5, 20'd6);
        for (int s = 0; s < 8; s++) begin
            sample_once(1, (s == 1) || (s == 3), sel, ok);
            exp_sel = (s < 4) ? 20'd5 : 20'd6;
            n_checks++; if (sel !== exp_sel) $display("FAIL bp_sel[%0d]: got %h want %h", s, sel, exp_sel); else n_pass++;
            if (s == 1 || s == 3) begin
                bad = 0;
                for (int k = 0; k < 10; k++) begin
                    if (CTR !== 1'b0 || BUSY !== 1'b1) bad++;
                    START = (k == 3);
                    if (k == 3) SEL_FIRST = 20'd9;
                    tick();
                end
                START = 1'b0;
                n_checks++; if (bad != 0) $display("FAIL bp_drain_idle[%0d]: got %0d bad cycles want 0", s, bad); else n_pass++;
                n_checks++; if (RO_SEL !== 20'd5) $display("FAIL bp_start_ignored[%0d]: got %h want 5", s, RO_SEL); else n_pass++;
                UART_EMPTY = 1'b1;
            end
        end
        tick();
        n_checks++; if (DONE !== 1'b1) $display("FAIL bp_done: got %b want 1", DONE); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [SEL_W-1:0] sel;
        logic [SEL_W-1:0] exp_sel;
        bit ok;
        start_run(1'b0, 20'hFFFFE, 20'h00001);
        for (int s = 0; s < 16; s++) begin
            sample_once(0, 1'b0, sel, ok);
            exp_sel = 20'hFFFFE + 20'(s / 4);
            n_checks++; if (sel !== exp_sel) $display("FAIL wrap_sel[%0d]: got %h want %h", s, sel, exp_sel); else n_pass++;
        end
        tick();
        n_checks++; if (DONE !== 1'b1 || RO_SEL !== 20'h00001) $display("FAIL wrap_done: got done=%b sel=%h want 1 00001", DONE, RO_SEL); else n_pass++;
    endtask

    task automatic test_fixed_stop();
        logic [SEL_W-1:0] sel;
        bit ok;
        int bad;
        int done_seen;
        bad = 0; done_seen = 0;
        start_run(1'b1, 20'h00A3C, 20'h00A3D);
        for (int i = 0; i < 10000; i++) begin
            sample_once(0, (i == 5000), sel, ok);
            UART_EMPTY = 1'b1;
            if (!ok) begin bad++; break; end
            if (sel !== 20'h00A3C) bad++;
            if (DONE !== 1'b0) done_seen++;
        end
        n_checks++; if (bad != 0)       $display("FAIL fixed_sel: got %0d bad samples want 0", bad);       else n_pass++;
        n_checks++; if (done_seen != 0) $display("FAIL fixed_no_fini: got %0d DONE cycles want 0", done_seen); else n_pass++;
        wait_ctr(ok);
        tick();
        n_checks++; if (CTR !== 1'b1) $display("FAIL fixed_osc: got CTR=%b want 1", CTR); else n_pass++;
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        n_checks++; if (CTR !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) $display("FAIL stop_idle: got ctr=%b busy=%b done=%b want 0 0 0", CTR, BUSY, DONE); else n_pass++;
        n_checks++; if (RO_SEL !== 20'h00A3C) $display("FAIL stop_sel_kept: got %h want 00a3c", RO_SEL); else n_pass++;
        TERO_OE = 1'b1;
        tick();
        TERO_OE = 1'b0;
        tick();
        n_checks++; if (BUSY !== 1'b0 || CTR !== 1'b0) $display("FAIL idle_oe_ignored: got busy=%b ctr=%b want 0 0", BUSY, CTR); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        int bad;
        start_run(1'b0, 20'h12345, 20'h12346);
        wait_ctr(ok);
        n_checks++; if (!ok || RO_SEL !== 20'h12345) $display("FAIL rst_pre_osc: got ok=%0d sel=%h want 1 12345", ok, RO_SEL); else n_pass++;
        #3;
        RST_N = 1'b0;
        #1;
        n_checks++; if (CTR !== 1'b0 || BUSY !== 1'b0 || RO_SEL !== '0) $display("FAIL rst_async: got ctr=%b busy=%b sel=%h want 0 0 0", CTR, BUSY, RO_SEL); else n_pass++;
        #1;
        RST_N = 1'b1;
        tick();
        SEL_FIRST = 20'd7;
        START = 1'b1; STOP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (BUSY !== 1'b0 || CTR !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (bad != 0)      $display("FAIL start_stop_same: got %0d busy cycles want 0", bad); else n_pass++;
        n_checks++; if (RO_SEL !== '0) $display("FAIL start_stop_sel: got %h want 0", RO_SEL);          else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef TERO_SWEEP_TIMEOUT_EN
        logic [SEL_W-1:0] sel;
        bit ok;
        start_run(1'b0, 20'd3, 20'd3);
        wait_ctr(ok);
        repeat (98) tick();
        n_checks++; if (TMO_PULSE !== 1'b0) $display("FAIL tmo_early: got %b want 0 at cycle 99", TMO_PULSE); else n_pass++;
        tick();
        n_checks++; if (TMO_PULSE !== 1'b1 || CTR !== 1'b1) $display("FAIL tmo_pulse: got pulse=%b ctr=%b want 1 1", TMO_PULSE, CTR); else n_pass++;
        tick();
        n_checks++; if (CTR !== 1'b0 || TMO_CNT !== 16'd1 || TMO_PULSE !== 1'b0) $display("FAIL tmo_after: got ctr=%b cnt=%h pulse=%b want 0 0001 0", CTR, TMO_CNT, TMO_PULSE); else n_pass++;
        for (int s = 0; s < 3; s++) sample_once(0, 1'b0, sel, ok);
        tick();
        n_checks++; if (DONE !== 1'b1) $display("FAIL tmo_sample_counted: got done=%b want 1", DONE); else n_pass++;
        start_run(1'b0, 20'd3, 20'd3);
        wait_ctr(ok);
        repeat (99) tick();
        TERO_OE = 1'b1;
        #1;
        n_checks++; if (TMO_PULSE !== 1'b0) $display("FAIL tmo_oe_wins: got %b want 0", TMO_PULSE); else n_pass++;
        tick();
        TERO_OE = 1'b0;
        n_checks++; if (TMO_CNT !== 16'd1 || CTR !== 1'b0) $display("FAIL tmo_cnt_held: got cnt=%h ctr=%b want 0001 0", TMO_CNT, CTR); else n_pass++;
`else
        n_checks++; if (TMO_PULSE !== 1'b0 || TMO_CNT !== 16'd0) $display("FAIL tmo_tied: got %b/%h want 0/0000", TMO_PULSE, TMO_CNT); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_back_pressure();
        test_wrap();
        test_fixed_stop();
        test_async_reset();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_tero_sweep_ctrl
`default_nettype wire
